dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port req  input  1  CPU access request; held high by CPU until ready.
REQ-004 SHALL have port we  input  1  1 = store, 0 = load.
REQ-005 SHALL have port addr  input  32  byte address.
REQ-006 SHALL have port funct3  input  3  access size/sign (RV32I load/store encoding).
REQ-007 SHALL have port wdata  input  32  store data, right-aligned.
REQ-008 SHALL have port sw  input  16  board switches.
REQ-009 SHALL have port rdata  output  32  load result, extended per funct3.
REQ-010 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err  output  1  error flag, valid only with ready.
REQ-012 SHALL have port led  output  16  LED register.

Function
REQ-013 SHALL implement FSM states IDLE, RD_WAIT, RESP; cycle T = IDLE cycle with req=1 (acceptance); addr, we, funct3, wdata latched at T.
REQ-014 SHALL map RAM at 0x0000_0000-0x0000_3FFF (4096 x 32, index addr[13:2], 1-cycle synchronous read), SW at 0xFFFF_FC00 (read-only, zero-extended), LED at 0xFFFF_FC60 (read/write, low 16 bits).
REQ-015 SHALL accept funct3 000/001/010/100/101 for loads and 000/001/010 for stores; any other code flags error.
REQ-016 SHALL flag error on misalignment (halfword addr[0]=1; word addr[1:0]!=0), unmapped address, or store to SW.
REQ-017 Error access: IDLE->RESP at T, ready=1 and err=1 at T+1, no state modified, rdata unchanged.
REQ-018 RAM load: IDLE->RD_WAIT at T, RD_WAIT->RESP at T+1 with extracted byte/halfword (lane addr[1:0]) sign- or zero-extended into rdata; ready=1 at T+2.
REQ-019 RAM store: byte-enable write committed at the clock edge ending T (sb one lane, sh two lanes, sw all); IDLE->RESP; ready=1 at T+1; rdata unchanged.
REQ-020 MMIO load/store: completed at edge ending T, ready=1 at T+1; LED store uses sb/sh/sw lane rules on bits 15:0 only.
REQ-021 RESP SHALL last exactly one cycle and return to IDLE; req in RESP is ignored; req high in the following IDLE cycle is a new acceptance.
REQ-022 ready and err SHALL be zero in all cycles other than RESP; rdata SHALL hold its value until the next successful load.
REQ-023 Store-after-load and load-after-store to same RAM word SHALL return updated data (no bypass needed: write commits before next acceptance).

Reset
REQ-024 rst=0 SHALL immediately force state IDLE, rdata=0, ready=0, err=0, led=0, synchronizer flops=0.
REQ-025 Reset mid-access (RD_WAIT or RESP) SHALL abort without a ready pulse; a store already committed at T stays committed; RAM contents are not cleared.
REQ-026 Deassertion SHALL be sampled such that the first acceptance can occur on the first clock edge with rst=1.

Configuration
REQ-027 Macro DMEM_SW_SYNC_EN defined: sw passes a 2-flop synchronizer; SW load returns switch value from >=2 edges earlier.
REQ-028 Macro DMEM_SW_SYNC_EN undefined: SW load samples sw directly at edge ending T; no synchronizer flops exist.

Verification
REQ-029 sw 0x12345678 to 0x100, then lw 0x100 -> ready at T+1 (store), T+2 (load), rdata=0x12345678, err=0.
REQ-030 sb 0xAB to 0x103, then lb 0x103 -> rdata=0xFFFFFFAB; lbu 0x103 -> rdata=0x000000AB; lhu 0x102 -> 0x0000AB34.
REQ-031 lw 0x102 and sh 0x101 -> ready=1, err=1 at T+1, RAM word unchanged, rdata unchanged.
REQ-032 sw 0xDEADBEEF to 0xFFFFFC60 -> led=0xBEEF; sw=0x00F0, lw 0xFFFFFC00 -> rdata=0x000000F0 (sync build: after 2 settle cycles); store to 0xFFFFFC00 -> err=1.
REQ-033 lw 0x200 accepted, rst=0 during RD_WAIT -> no ready pulse, rdata=0, led=0; next lw 0x200 after release returns pre-reset RAM value.
REQ-034 lw 0x8000 (unmapped) and funct3=011 load -> err=1 at T+1; req held high through RESP -> exactly one ready per request.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bus between a CPU (master) and dmem_responder (slave).
// The CPU holds req until a one-cycle ready pulse. err is meaningful only alongside ready.
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [2:0]  funct3;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (
    output req, we, addr, funct3, wdata,
    input  rdata, ready, err
  );

  modport slave (
    input  req, we, addr, funct3, wdata,
    output rdata, ready, err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: RV32I data-memory responder with the following map:
//   16 KiB RAM at 0x0000_0000, switches at 0xFFFF_FC00 (read-only),
//   and the LED register at 0xFFFF_FC60.
// The optional macro DMEM_SW_SYNC_EN routes sw through a 2-flop synchronizer.
// When the macro is undefined, sw is sampled directly.
// RAM loads take two cycles to ready; stores, MMIO and errors take one.
module dmem_responder (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus,
  input  logic [15:0]      sw,
  output logic [15:0]      led
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  state_t      r_state;
  logic [31:0] r_mem [4096];
  logic [31:0] r_ram_q;
  logic [1:0]  r_lane;
  logic [2:0]  r_funct3;
  logic [31:0] r_rdata;
  logic        r_ready;
  logic        r_err;
  logic [15:0] r_led;

  logic [15:0] w_sw;
  logic        w_accept;
  logic        w_is_ram;
  logic        w_is_sw;
  logic        w_is_led;
  logic        w_f3_ok;
  logic        w_misalign;
  logic        w_err;
  logic        w_ram_wr;
  logic        w_led_wr;
  logic [3:0]  w_be;
  logic [31:0] w_wlane;
  logic [31:0] w_mmio_word;
  logic [15:0] w_led_next;
  logic [11:0] w_idx;

`ifdef DMEM_SW_SYNC_EN
  logic [15:0] r_sw_s1;
  logic [15:0] r_sw_s2;

  // Two-flop synchronizer for the asynchronous board switches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
    end
  end

  assign w_sw = r_sw_s2;
`else
  assign w_sw = sw;
`endif

  // Sign/zero extension of the addressed byte or halfword of a 32-bit word
  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [1:0]  lane,
                                          input logic [2:0]  f3);
    logic [31:0] s;
    logic [7:0]  b;
    logic [15:0] h;
    s = word >> {lane, 3'b000};
    b = s[7:0];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b100:  extract = {24'b0, b};
      3'b101:  extract = {16'b0, h};
      default: extract = word;
    endcase
  endfunction

  assign w_idx       = bus.addr[13:2];
  assign w_mmio_word = w_is_sw ? {16'b0, w_sw} : {16'b0, r_led};

  // Address decode, error classification and byte-lane steering for the request at T
  always_comb begin
    w_accept   = rst && (r_state == IDLE) && bus.req;
    w_is_ram   = (bus.addr[31:14] == '0);
    w_is_sw    = (bus.addr[31:2] == 30'h3FFF_FF00);
    w_is_led   = (bus.addr[31:2] == 30'h3FFF_FF18);

    w_f3_ok = 1'b0;
    case (bus.funct3)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = !bus.we;
      default:                w_f3_ok = 1'b0;
    endcase

    w_misalign = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                 ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));

    w_err = !w_f3_ok || w_misalign || !(w_is_ram || w_is_sw || w_is_led) ||
            (bus.we && w_is_sw);

    w_be    = '0;
    w_wlane = bus.wdata;
    case (bus.funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << bus.addr[1:0];
        w_wlane = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        w_be    = bus.addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{bus.wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wlane = bus.wdata;
      end
    endcase

    w_ram_wr = w_accept && !w_err && bus.we && w_is_ram;
    w_led_wr = w_accept && !w_err && bus.we && w_is_led;

    w_led_next = r_led;
    if (w_be[0]) w_led_next[7:0]  = w_wlane[7:0];
    if (w_be[1]) w_led_next[15:8] = w_wlane[15:8];
  end

  // RAM: byte-enable write and synchronous read, both on the accepting edge
  always_ff @(posedge clk) begin
    if (w_ram_wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][i*8 +: 8] <= w_wlane[i*8 +: 8];
      end
    end
    if (w_accept) r_ram_q <= r_mem[w_idx];
  end

  // Access FSM with registered response outputs and LED register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_rdata  <= '0;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
      r_led    <= '0;
      r_lane   <= '0;
      r_funct3 <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          if (w_accept) begin
            r_lane   <= bus.addr[1:0];
            r_funct3 <= bus.funct3;
            if (w_err) begin
              r_state <= RESP;
              r_ready <= 1'b1;
              r_err   <= 1'b1;
            end else if (w_is_ram && !bus.we) begin
              r_state <= RD_WAIT;
            end else begin
              r_state <= RESP;
              r_ready <= 1'b1;
              if (!bus.we && !w_is_ram) r_rdata <= extract(w_mmio_word, bus.addr[1:0], bus.funct3);
              if (w_led_wr) r_led <= w_led_next;
            end
          end
        end
        RD_WAIT: begin
          r_rdata <= extract(r_ram_q, r_lane, r_funct3);
          r_ready <= 1'b1;
          r_state <= RESP;
        end
        RESP: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.ready = r_ready;
  assign bus.err   = r_err;
  assign led       = r_led;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder with hand-computed expectations.
// Inputs are driven, and outputs are sampled, on the falling clock edge.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw;
  logic [15:0] led;

  dmem_responder_if bus();

  dmem_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .sw  (sw),
    .led (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic void add(input logic we, input logic [31:0] a, input logic [2:0] f3,
                              input logic [31:0] wd, input logic [31:0] er, input logic ee,
                              input int el, input logic [15:0] eled);
    vecs.push_back('{we, a, f3, wd, er, ee, el, eled});
  endfunction

  // Issue one request from IDLE; returns rdata/err at the ready pulse and latency in cycles.
  task automatic access(input logic we_i, input logic [31:0] a, input logic [2:0] f,
                        input logic [31:0] wd, input string name,
                        output logic [31:0] rd, output logic e, output int lat);
    bus.req    = 1'b1;
    bus.we     = we_i;
    bus.addr   = a;
    bus.funct3 = f;
    bus.wdata  = wd;
    lat = 0;
    rd  = 'x;
    e   = 1'bx;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        lat = n;
        rd  = bus.rdata;
        e   = bus.err;
        break;
      end
      chk({name, "_err_quiet"}, {31'b0, bus.err}, 32'h0);
    end
    bus.req = 1'b0;
    @(negedge clk);
    chk({name, "_ready_1cyc"}, {31'b0, bus.ready}, 32'h0);
  endtask

  // Hold req high for six cycles and record the ready/err pattern (MSB = T+1).
  task automatic hold_seq(input logic [31:0] a, input logic [2:0] f,
                          input logic [5:0] exp_rdy, input logic [5:0] exp_err,
                          input string name);
    logic [5:0] r;
    logic [5:0] e;
    bus.req    = 1'b1;
    bus.we     = 1'b0;
    bus.addr   = a;
    bus.funct3 = f;
    bus.wdata  = '0;
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      r[5-k] = bus.ready;
      e[5-k] = bus.err;
    end
    bus.req = 1'b0;
    @(negedge clk);
    chk({name, "_ready_pat"}, {26'b0, r}, {26'b0, exp_rdy});
    chk({name, "_err_pat"},   {26'b0, e}, {26'b0, exp_err});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;

    rst        = 1'b0;
    sw         = 16'h00F0;
    bus.req    = 1'b0;
    bus.we     = 1'b0;
    bus.addr   = '0;
    bus.funct3 = '0;
    bus.wdata  = '0;
    #1;
    chk("rst_ready", {31'b0, bus.ready}, 32'h0);
    chk("rst_err",   {31'b0, bus.err},   32'h0);
    chk("rst_rdata", bus.rdata,          32'h0);
    chk("rst_led",   {16'b0, led},       32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    //  we    addr          f3    wdata         exp_rdata     err  lat led
    add(1'b1, 32'h0000_0100, 3'd2, 32'h1234_5678, 32'h0000_0000, 1'b0, 1, 16'h0000);
    add(1'b0, 32'h0000_0100, 3'd2, 32'h0,         32'h1234_5678, 1'b0, 2, 16'h0000);
    add(1'b1, 32'h0000_0103, 3'd0, 32'h0000_00AB, 32'h1234_5678, 1'b0, 1, 16'h0000);
    add(1'b0, 32'h0000_0103, 3'd0, 32'h0,         32'hFFFF_FFAB, 1'b0, 2, 16'h0000);
    add(1'b0, 32'h0000_0103, 3'd4, 32'h0,         32'h0000_00AB, 1'b0, 2, 16'h0000);
    add(1'b0, 32'h0000_0102, 3'd5, 32'h0,         32'h0000_AB34, 1'b0, 2, 16'h0000);
    add(1'b0, 32'h0000_0102, 3'd2, 32'h0,         32'h0000_AB34, 1'b1, 1, 16'h0000);
    add(1'b1, 32'h0000_0101, 3'd1, 32'h0000_FFFF, 32'h0000_AB34, 1'b1, 1, 16'h0000);
    add(1'b0, 32'h0000_0100, 3'd2, 32'h0,         32'hAB34_5678, 1'b0, 2, 16'h0000);
    add(1'b0, 32'h0000_0100, 3'd1, 32'h0,         32'h0000_5678, 1'b0, 2, 16'h0000);
    add(1'b0, 32'h0000_0102, 3'd1, 32'h0,         32'hFFFF_AB34, 1'b0, 2, 16'h0000);
    add(1'b1, 32'h0000_0106, 3'd1, 32'h1234_8001, 32'hFFFF_AB34, 1'b0, 1, 16'h0000);
    add(1'b0, 32'h0000_0106, 3'd1, 32'h0,         32'hFFFF_8001, 1'b0, 2, 16'h0000);
    add(1'b0, 32'h0000_0106, 3'd5, 32'h0,         32'h0000_8001, 1'b0, 2, 16'h0000);
    add(1'b1, 32'h0000_0104, 3'd0, 32'h0000_017F, 32'h0000_8001, 1'b0, 1, 16'h0000);
    add(1'b0, 32'h0000_0104, 3'd0, 32'h0,         32'h0000_007F, 1'b0, 2, 16'h0000);
    add(1'b0, 32'h0000_0107, 3'd0, 32'h0,         32'hFFFF_FF80, 1'b0, 2, 16'h0000);
    add(1'b1, 32'hFFFF_FC60, 3'd2, 32'hDEAD_BEEF, 32'hFFFF_FF80, 1'b0, 1, 16'hBEEF);
    add(1'b0, 32'hFFFF_FC60, 3'd2, 32'h0,         32'h0000_BEEF, 1'b0, 1, 16'hBEEF);
    add(1'b1, 32'hFFFF_FC61, 3'd0, 32'h0000_0012, 32'h0000_BEEF, 1'b0, 1, 16'h12EF);
    add(1'b0, 32'hFFFF_FC60, 3'd1, 32'h0,         32'h0000_12EF, 1'b0, 1, 16'h12EF);
    add(1'b0, 32'hFFFF_FC60, 3'd0, 32'h0,         32'hFFFF_FFEF, 1'b0, 1, 16'h12EF);
    add(1'b0, 32'hFFFF_FC00, 3'd2, 32'h0,         32'h0000_00F0, 1'b0, 1, 16'h12EF);
    add(1'b1, 32'hFFFF_FC00, 3'd2, 32'h0000_0001, 32'h0000_00F0, 1'b1, 1, 16'h12EF);
    add(1'b0, 32'h0000_8000, 3'd2, 32'h0,         32'h0000_00F0, 1'b1, 1, 16'h12EF);
    add(1'b0, 32'h0000_0100, 3'd3, 32'h0,         32'h0000_00F0, 1'b1, 1, 16'h12EF);
    add(1'b1, 32'h0000_0100, 3'd4, 32'h0,         32'h0000_00F0, 1'b1, 1, 16'h12EF);
    add(1'b0, 32'h0000_0100, 3'd2, 32'h0,         32'hAB34_5678, 1'b0, 2, 16'h12EF);
    add(1'b0, 32'h0000_4000, 3'd2, 32'h0,         32'hAB34_5678, 1'b1, 1, 16'h12EF);
    add(1'b0, 32'hFFFF_FC04, 3'd2, 32'h0,         32'hAB34_5678, 1'b1, 1, 16'h12EF);
    add(1'b1, 32'hFFFF_FC62, 3'd1, 32'h0000_FFFF, 32'hAB34_5678, 1'b0, 1, 16'h12EF);
    add(1'b0, 32'hFFFF_FC01, 3'd4, 32'h0,         32'h0000_0000, 1'b0, 1, 16'h12EF);

    for (int i = 0; i < vecs.size(); i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wdata,
             $sformatf("v%0d", i), rd, e, lat);
      chk($sformatf("v%0d_lat", i),   lat,               vecs[i].exp_lat);
      chk($sformatf("v%0d_err", i),   {31'b0, e},        {31'b0, vecs[i].exp_err});
      chk($sformatf("v%0d_rdata", i), rd,                vecs[i].exp_rdata);
      chk($sformatf("v%0d_led", i),   {16'b0, led},      {16'b0, vecs[i].exp_led});
    end

    // req held high: each acceptance yields exactly one ready pulse
    hold_seq(32'h0000_8000, 3'd2, 6'b101010, 6'b101010, "hold_err");
    hold_seq(32'h0000_0100, 3'd2, 6'b010010, 6'b000000, "hold_ld");

    // reset during RD_WAIT aborts; RAM keeps its contents
    access(1'b1, 32'h0000_0200, 3'd2, 32'hCAFE_F00D, "st200", rd, e, lat);
    chk("st200_lat", lat, 1);
    bus.req    = 1'b1;
    bus.we     = 1'b0;
    bus.addr   = 32'h0000_0200;
    bus.funct3 = 3'd2;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_ready", {31'b0, bus.ready}, 32'h0);
    chk("abort_err",   {31'b0, bus.err},   32'h0);
    chk("abort_rdata", bus.rdata,          32'h0);
    chk("abort_led",   {16'b0, led},       32'h0);
    bus.req = 1'b0;
    @(negedge clk);
    chk("abort_ready_hold", {31'b0, bus.ready}, 32'h0);
    rst = 1'b1;
    access(1'b0, 32'h0000_0200, 3'd2, 32'h0, "ld200", rd, e, lat);
    chk("ld200_lat",   lat,        2);
    chk("ld200_rdata", rd,         32'hCAFE_F00D);
    chk("ld200_err",   {31'b0, e}, 32'h0);

    // reset during RESP of a store: ready is killed, store stays committed
    bus.req    = 1'b1;
    bus.we     = 1'b1;
    bus.addr   = 32'h0000_0300;
    bus.funct3 = 3'd2;
    bus.wdata  = 32'h5A5A_1234;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("resp_abort_ready", {31'b0, bus.ready}, 32'h0);
    bus.req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    access(1'b0, 32'h0000_0300, 3'd2, 32'h0, "ld300", rd, e, lat);
    chk("ld300_lat",   lat, 2);
    chk("ld300_rdata", rd,  32'h5A5A_1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
